// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth signed multiplier: N iterations through a shared (N+1)-bit adder.
// Optional abort input enabled by defining BOOTH_ABORT_EN.
module booth_seq_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef BOOTH_ABORT_EN
    input  logic           abort,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N:0]    acc;
    logic [N-1:0]  q;
    logic [N-1:0]  m;
    logic          q_1;
    logic [CW-1:0] cnt;

    logic [N:0]    msx;
    logic [N:0]    operand;
    logic [N:0]    sum;
    logic          sub;
    logic          addsub;
    logic [N:0]    acc_sh;
    logic [N-1:0]  q_sh;
    logic          last;

    // One Booth iteration: shared add/sub (invert plus carry-in), then arithmetic shift.
    always_comb begin
        msx     = {m[N-1], m};
        sub     = q[0] & ~q_1;
        addsub  = q[0] ^ q_1;
        operand = sub ? ~msx : msx;
        sum     = addsub ? (acc + operand + (N+1)'(sub)) : acc;
        acc_sh  = {sum[N], sum[N:1]};
        q_sh    = {sum[0], q[N-1:1]};
        last    = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        q_1   <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= STEP;
                    end
                end
                STEP: begin
`ifdef BOOTH_ABORT_EN
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else
`endif
                    begin
                        acc <= acc_sh;
                        q   <= q_sh;
                        q_1 <= q[0];
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            product <= {acc_sh[N-1:0], q_sh};
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl at N=4; abort scenarios built when BOOTH_ABORT_EN is defined.
module tb_booth_seq_ctrl;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
`ifdef BOOTH_ABORT_EN
    logic           abort;
`endif
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int tests;
    int fails;

    booth_seq_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef BOOTH_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply; lat counts edges from the start edge to the edge raising done, or -1 on timeout.
    task automatic run_mult(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                            output logic [2*N-1:0] p, output int lat);
        a = ta;
        b = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        p = product;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef BOOTH_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (product !== 8'h00) begin fails++; $display("FAIL reset_product got %h exp 00", product); end
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_basic();
        logic [N-1:0]   va [8];
        logic [N-1:0]   vb [8];
        logic [2*N-1:0] vp [8];
        logic [2*N-1:0] p;
        int             lat;
        va = '{4'h3, 4'h8, 4'h8, 4'h0, 4'hF, 4'h7, 4'hD, 4'h7};
        vb = '{4'h5, 4'h8, 4'h7, 4'hF, 4'hF, 4'h8, 4'h6, 4'h7};
        vp = '{8'h0F, 8'h40, 8'hC8, 8'h00, 8'h01, 8'hC8, 8'hEE, 8'h31};
        for (int i = 0; i < 8; i++) begin
            run_mult(va[i], vb[i], p, lat);
            tests++; if (lat != 5) begin fails++; $display("FAIL basic_latency[%0d] got %0d exp 5", i, lat); end
            tests++; if (p !== vp[i]) begin fails++; $display("FAIL basic_product[%0d] %h*%h got %h exp %h", i, va[i], vb[i], p, vp[i]); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_in_done[%0d] got %b exp 1", i, busy); end
            tick();
            tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_after_done[%0d] done=%b busy=%b exp 0/0", i, done, busy); end
            tests++; if (product !== vp[i]) begin fails++; $display("FAIL basic_hold[%0d] got %h exp %h", i, product, vp[i]); end
        end
    endtask

    // Operands changed after the start edge must not affect the result.
    task automatic test_operand_capture();
        int lat;
        a = 4'hB;
        b = 4'h3;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 4'h1;
        b = 4'h1;
        lat = -1;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin lat = i; break; end
        end
        tests++; if (lat != 5) begin fails++; $display("FAIL capture_latency got %0d exp 5", lat); end
        tests++; if (product !== 8'hF1) begin fails++; $display("FAIL capture_product got %h exp f1", product); end
        tick();
    endtask

    // Start pulses while busy are dropped, not queued.
    task automatic test_start_ignored();
        int dones;
        a = 4'h2;
        b = 4'h2;
        start = 1'b1;
        tick();
        a = 4'h7;
        b = 4'h7;
        tick();
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        tests++; if (dones != 1) begin fails++; $display("FAIL ignored_done_count got %0d exp 1", dones); end
        tests++; if (product !== 8'h04) begin fails++; $display("FAIL ignored_product got %h exp 04", product); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignored_idle_busy got %b exp 0", busy); end
    endtask

    // Start held high: one result every N+2 cycles, busy low only in IDLE.
    task automatic test_back_to_back();
        int bad_done;
        int bad_busy;
        int bad_prod;
        int dones;
        bad_done = 0;
        bad_busy = 0;
        bad_prod = 0;
        dones = 0;
        a = 4'h2;
        b = 4'h3;
        start = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (done !== ((e % 6) == 4)) bad_done++;
            if (busy !== ((e % 6) != 5)) bad_busy++;
            if (done === 1'b1) begin
                dones++;
                if (product !== 8'h06) bad_prod++;
            end
        end
        start = 1'b0;
        tests++; if (bad_done != 0) begin fails++; $display("FAIL b2b_done_pattern got %0d bad cycles exp 0", bad_done); end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL b2b_busy_pattern got %0d bad cycles exp 0", bad_busy); end
        tests++; if (bad_prod != 0) begin fails++; $display("FAIL b2b_product got %0d bad results exp 0", bad_prod); end
        tests++; if (dones != 3) begin fails++; $display("FAIL b2b_done_count got %0d exp 3", dones); end
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset_mid();
        int dones;
        logic [2*N-1:0] p;
        int lat;
        a = 4'h3;
        b = 4'h5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_ctrl busy=%b done=%b exp 0/0", busy, done); end
        tests++; if (product !== 8'h00) begin fails++; $display("FAIL midreset_product got %h exp 00", product); end
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        tests++; if (dones != 0) begin fails++; $display("FAIL midreset_no_done got %0d pulses exp 0", dones); end
        run_mult(4'h3, 4'h5, p, lat);
        tests++; if (lat != 5 || p !== 8'h0F) begin fails++; $display("FAIL midreset_recover lat=%0d p=%h exp 5/0f", lat, p); end
        tick();
    endtask

`ifdef BOOTH_ABORT_EN
    task automatic test_abort();
        int dones;
        logic [2*N-1:0] p;
        int lat;
        a = 4'h3;
        b = 4'h3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_ctrl busy=%b done=%b exp 0/0", busy, done); end
        tests++; if (product !== 8'h0F) begin fails++; $display("FAIL abort_product got %h exp 0f", product); end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        tests++; if (dones != 0) begin fails++; $display("FAIL abort_no_done got %0d pulses exp 0", dones); end
        abort = 1'b1;
        tick();
        tick();
        tests++; if (busy !== 1'b0 || product !== 8'h0F) begin fails++; $display("FAIL abort_idle busy=%b p=%h exp 0/0f", busy, product); end
        abort = 1'b0;
        run_mult(4'h2, 4'hD, p, lat);
        tests++; if (lat != 5 || p !== 8'hFA) begin fails++; $display("FAIL abort_recover lat=%0d p=%h exp 5/fa", lat, p); end
        tick();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_operand_capture();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef BOOTH_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 Parameter: N, default 4, operand width in bits; legal values 2..8.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin one multiply; sampled only in IDLE.
REQ-006 Port: a  input  N  signed multiplicand (two's complement).
REQ-007 Port: b  input  N  signed multiplier (two's complement).
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: done  output  1  one-cycle pulse; product valid while high.
REQ-010 Port: product  output  2N  signed result; holds until the next done.
REQ-011 Port (only with BOOTH_ABORT_EN): abort  input  1  cancel the operation in progress.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, STEP, DONE.
REQ-013 IDLE with start=1 at edge k: capture M=a, Q=b, Q_1=0, A=0 (N+1 bits), cnt=0; go to STEP.
REQ-014 STEP, edges k+1..k+N: one radix-2 Booth iteration per edge; cnt increments by 1 per iteration.
REQ-015 Booth rule on {Q[0],Q_1}: 00/11 -> A unchanged; 01 -> A=A+sext(M); 10 -> A=A+~sext(M)+1.
REQ-016 The add/sub SHALL be one shared (N+1)-bit adder with M sign-extended by one bit, and subtraction formed as invert-plus-carry-in; no carry-out is kept.
REQ-017 After the add/sub in the same edge: arithmetic right shift of {A,Q,Q_1} by one, with A[N] replicated.
REQ-018 At edge k+N (cnt=N-1): go to DONE; product<={A[N-1:0],Q} after the final shift.
REQ-019 In DONE, done=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
REQ-020 Latency: done is high in the cycle after edge k+N, i.e. N+1 edges after start is sampled.
REQ-021 start while busy=1 SHALL be ignored; no queuing.
REQ-022 start in the DONE cycle SHALL be ignored; back-to-back issue therefore takes N+2 cycles.
REQ-023 a and b SHALL be sampled only at edge k; changes after edge k do not affect the result.
REQ-024 product SHALL equal the exact signed a*b for every operand pair, including a=b=-2^(N-1).
REQ-025 product SHALL change only at the transition into DONE.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, product=0, A=0, Q=0, Q_1=0, M=0, cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no done pulse follows.
REQ-028 After rst_n deasserts, the first start is accepted at the first rising edge with start=1.

Configuration
REQ-029 Macro BOOTH_ABORT_EN defined: an abort port is present; abort=1 in STEP at an edge returns the FSM to IDLE with product unchanged and no done pulse; abort in IDLE or DONE has no effect; abort takes priority over the iteration at that edge.
REQ-030 Macro BOOTH_ABORT_EN undefined: no abort port exists, and every accepted start produces exactly one done.

Verification
REQ-031 N=4, a=3, b=5, start for 1 cycle -> done 5 edges later, product=8'h0F.
REQ-032 N=4, a=-8, b=-8 -> product=8'h40 (+64); a=-8, b=7 -> product=8'hC8 (-56).
REQ-033 N=4, a=0, b=-1 -> product=8'h00; a=-1, b=-1 -> product=8'h01.
REQ-034 start held high continuously for 20 cycles with a=2, b=3 -> done every 6th cycle, product=8'h06, busy low only in the IDLE cycles.
REQ-035 rst_n pulsed low at edge k+2 of an operation -> all outputs 0 at once, no done pulse, and the next start completes normally.
REQ-036 BOOTH_ABORT_EN defined: abort at edge k+2 -> IDLE, no done, product keeps its previous value; abort while IDLE has no effect.
